// File: rtl/alu_pkg.sv
// Shared ALUOp encodings and execute-stage FSM state type.
// The instruction decoder imports the same constants so both ends agree on the encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_MFHI = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_JMP  = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } alu_state_e;

  function automatic logic is_mult_op(input logic [3:0] op);
    return op == ALU_MULT;
  endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add multiplier: retires STEP multiplier bits per cycle, no early exit.
// With ALU_MULT_HI_EN the accumulator is 2*WIDTH wide and the upper half is kept in hi.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
`ifdef ALU_MULT_HI_EN
  ,
  output logic [WIDTH-1:0] hi
`endif
);

`ifdef ALU_MULT_HI_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif
  localparam int STEPS = WIDTH / STEP;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [ACC_W-1:0] mcand;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] acc_next;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // Partial product for the low STEP multiplier bits as a sum of shifted multiplicands.
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    acc_next = acc + partial;
  end

  assign done    = (cnt == CNT_W'(1));
  assign product = acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= ACC_W'(a);
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(STEPS);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << STEP;
      mplier <= mplier >> STEP;
      cnt    <= cnt - CNT_W'(1);
    end
  end

`ifdef ALU_MULT_HI_EN
  always_ff @(posedge clk) begin
    if (reset) hi <= '0;
    else if (done) hi <= acc_next[ACC_W-1:WIDTH];
  end
`endif

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt plus a stalling iterative multiply.
// Optional macro ALU_MULT_HI_EN adds the HI register and the mfhi op (1001).
//
//   state   | meaning
//   IDLE    | accepting ops; single-cycle ops complete next cycle
//   MULT    | multiplier running, Stall high, in_valid ignored
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int MULT_STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  alu_state_e       state, state_next;
  logic             mult_start;
  logic             single_fire;
  logic             mult_done;
  logic [WIDTH-1:0] mult_product;
  logic [WIDTH-1:0] alu_res;
`ifdef ALU_MULT_HI_EN
  logic [WIDTH-1:0] mult_hi;
`endif

  alu_mult_seq #(
    .WIDTH (WIDTH),
    .STEP  (MULT_STEP_BITS)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start),
    .a       (A),
    .b       (B),
    .done    (mult_done),
    .product (mult_product)
`ifdef ALU_MULT_HI_EN
    ,
    .hi      (mult_hi)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid && is_mult_op(ALUOp)) state_next = ST_MULT;
      ST_MULT: if (mult_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall is decoded from state only, so the issue cycle of a mult is not stalled.
  always_comb begin
    Stall       = (state == ST_MULT);
    mult_start  = (state == ST_IDLE) && in_valid && is_mult_op(ALUOp);
    single_fire = (state == ST_IDLE) && in_valid && !is_mult_op(ALUOp);
  end

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      ALU_AND: alu_res = A & B;
      ALU_OR:  alu_res = A | B;
      ALU_XOR: alu_res = A ^ B;
      ALU_NOR: alu_res = ~(A | B);
      ALU_ADD: alu_res = A + B;
      ALU_SUB: alu_res = A - B;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef ALU_MULT_HI_EN
      ALU_MFHI: alu_res = mult_hi;
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
    end else if (single_fire) begin
      out_valid <= 1'b1;
      Result    <= alu_res;
      Zero      <= (alu_res == '0);
    end else if (state == ST_MULT && mult_done) begin
      out_valid <= 1'b1;
      Result    <= mult_product;
      Zero      <= (mult_product == '0);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed plan cases plus randomized ops against a
// plain-arithmetic reference model. A second instance runs with MULT_STEP_BITS=4.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  ALUOp;
  logic [31:0] A, B;
  logic        Stall, out_valid, Zero;
  logic [31:0] Result;
  logic        Stall4, out_valid4, Zero4;
  logic [31:0] Result4;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_hi = 32'h0;

  ex_alu_unit #(.WIDTH(32), .MULT_STEP_BITS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp), .A(A), .B(B),
    .Stall(Stall), .out_valid(out_valid), .Result(Result), .Zero(Zero)
  );

  ex_alu_unit #(.WIDTH(32), .MULT_STEP_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp), .A(A), .B(B),
    .Stall(Stall4), .out_valid(out_valid4), .Result(Result4), .Zero(Zero4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1101: return a ^ b;
      4'b1100: return ~(a | b);
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a * b;
`ifdef ALU_MULT_HI_EN
      4'b1001: return hi;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL %s out_valid: got %b expected 1", name, out_valid); end
    tests++;
    if (Result !== exp) begin fails++; $display("FAIL %s Result: got %h expected %h", name, Result, exp); end
    tests++;
    if (Zero !== (exp == 32'd0)) begin fails++; $display("FAIL %s Zero: got %b expected %b", name, Zero, exp == 32'd0); end
    step();
    tests++;
    if (out_valid !== 1'b0 || Result !== exp) begin
      fails++; $display("FAIL %s hold: out_valid %b Result %h expected 0 / %h", name, out_valid, Result, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; ALUOp = 4'h0; A = '0; B = '0;
    step(); step();
    tests++;
    if (Stall !== 1'b0 || out_valid !== 1'b0 || Result !== 32'h0 || Zero !== 1'b0) begin
      fails++; $display("FAIL reset: Stall %b out_valid %b Result %h Zero %b expected all 0", Stall, out_valid, Result, Zero);
    end
    tests++;
    if (Stall4 !== 1'b0 || out_valid4 !== 1'b0 || Result4 !== 32'h0 || Zero4 !== 1'b0) begin
      fails++; $display("FAIL reset4: Stall %b out_valid %b Result %h Zero %b expected all 0", Stall4, out_valid4, Result4, Zero4);
    end
    reset = 1'b0;
    model_hi = 32'h0;
    step();
  endtask

  task automatic test_directed();
    single_op("add_7_5", 4'b0010, 32'd7, 32'd5, 32'd12);
    single_op("sub_9_9", 4'b0110, 32'd9, 32'd9, 32'd0);
    single_op("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1);
    single_op("slt_pos", 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0);
    single_op("jmp", 4'b1111, $urandom, $urandom, 32'd0);
    single_op("unk_1010", 4'b1010, $urandom, $urandom, 32'd0);
    single_op("nor_0", 4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    held = Result;
    for (int i = 0; i < 80; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'b1000);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      in_valid = ($urandom_range(0, 4) != 0);
      ALUOp = op; A = a; B = b;
      exp = model(op, a, b, model_hi);
      step();
      if (in_valid) begin
        tests++;
        if (out_valid !== 1'b1 || Result !== exp || Zero !== (exp == 32'd0)) begin
          fails++; $display("FAIL b2b op %b: out_valid %b Result %h Zero %b expected 1 / %h / %b",
                            op, out_valid, Result, Zero, exp, exp == 32'd0);
        end
        held = exp;
      end else begin
        tests++;
        if (out_valid !== 1'b0 || Result !== held) begin
          fails++; $display("FAIL b2b idle: out_valid %b Result %h expected 0 / %h", out_valid, Result, held);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  // Mult at edge N with an ADD held behind it; cycle k is the cycle after edge N+k-1.
  task automatic test_mult(input string name, input logic [31:0] a, input logic [31:0] b);
    int stall_cnt, mult_cyc, add_cyc, cyc4;
    logic [31:0] mult_res, add_res, res4, ha, hb, exp;
    stall_cnt = 0; mult_cyc = 0; add_cyc = 0; cyc4 = 0;
    mult_res = '0; add_res = '0; res4 = '0;
    ha = $urandom; hb = $urandom;
    exp = model(4'b1000, a, b, model_hi);
    in_valid = 1'b1; ALUOp = 4'b1000; A = a; B = b;
    step();
    ALUOp = 4'b0010; A = ha; B = hb;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (Stall) stall_cnt++;
      if (out_valid) begin
        if (mult_cyc == 0) begin mult_cyc = cyc; mult_res = Result; end
        else if (add_cyc == 0) begin add_cyc = cyc; add_res = Result; end
      end
      if (out_valid4 && cyc4 == 0) begin cyc4 = cyc; res4 = Result4; end
      step();
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (stall_cnt != 32) begin fails++; $display("FAIL %s stall cycles: got %0d expected 32", name, stall_cnt); end
    tests++;
    if (mult_cyc != 33) begin fails++; $display("FAIL %s mult done cycle: got %0d expected 33", name, mult_cyc); end
    tests++;
    if (mult_res !== exp) begin fails++; $display("FAIL %s product: got %h expected %h", name, mult_res, exp); end
    tests++;
    if (add_cyc != 34 || add_res !== ha + hb) begin
      fails++; $display("FAIL %s held add: cycle %0d Result %h expected 34 / %h", name, add_cyc, add_res, ha + hb);
    end
    tests++;
    if (cyc4 != 9 || res4 !== exp) begin
      fails++; $display("FAIL %s step4: cycle %0d Result %h expected 9 / %h", name, cyc4, res4, exp);
    end
    model_hi = 32'((64'(a) * 64'(b)) >> 32);
  endtask

  task automatic test_hi();
    logic [31:0] exp_hi;
    test_mult("mult_ones", 32'hFFFFFFFF, 32'hFFFFFFFF);
`ifdef ALU_MULT_HI_EN
    exp_hi = 32'hFFFFFFFE;
`else
    exp_hi = 32'h0;
`endif
    single_op("mfhi", 4'b1001, $urandom, $urandom, exp_hi);
  endtask

  task automatic test_back_to_back_mult();
    logic [31:0] a1, b1, a2, b2;
    int c1, c2;
    logic [31:0] r1, r2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    c1 = 0; c2 = 0; r1 = '0; r2 = '0;
    in_valid = 1'b1; ALUOp = 4'b1000; A = a1; B = b1;
    step();
    A = a2; B = b2;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      if (c1 != 0 && cyc == c1 + 1) in_valid = 1'b0;
      if (out_valid) begin
        if (c1 == 0) begin c1 = cyc; r1 = Result; end
        else if (c2 == 0) begin c2 = cyc; r2 = Result; end
      end
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (c1 != 33 || r1 !== a1 * b1) begin
      fails++; $display("FAIL b2b_mult first: cycle %0d Result %h expected 33 / %h", c1, r1, a1 * b1);
    end
    tests++;
    if (c2 != 66 || r2 !== a2 * b2) begin
      fails++; $display("FAIL b2b_mult second: cycle %0d Result %h expected 66 / %h", c2, r2, a2 * b2);
    end
    model_hi = 32'((64'(a2) * 64'(b2)) >> 32);
    single_op("mfhi_after_b2b", 4'b1001, 32'd0, 32'd0, model(4'b1001, 32'd0, 32'd0, model_hi));
  endtask

  task automatic test_reset_mid_mult();
    logic [31:0] a, b;
    in_valid = 1'b1; ALUOp = 4'b1000; A = $urandom | 32'h1; B = $urandom | 32'h1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    tests++;
    if (Stall !== 1'b0 || out_valid !== 1'b0 || Result !== 32'h0 || Zero !== 1'b0) begin
      fails++; $display("FAIL mid_reset: Stall %b out_valid %b Result %h Zero %b expected all 0", Stall, out_valid, Result, Zero);
    end
    reset = 1'b0;
    model_hi = 32'h0;
    for (int i = 0; i < 30; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || Stall !== 1'b0) begin
        fails++; $display("FAIL mid_reset aborted: out_valid %b Stall %b expected 0 / 0", out_valid, Stall);
      end
    end
    a = $urandom; b = $urandom;
    single_op("add_after_reset", 4'b0010, a, b, a + b);
    single_op("mfhi_after_reset", 4'b1001, 32'd0, 32'd0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mult("mult_plan", 32'd123456, 32'd789);
    tests++;
    if (32'd123456 * 32'd789 !== model(4'b1000, 32'd123456, 32'd789, 32'd0) || Result !== 32'd123456 + 32'd0 + Result - 32'd123456) begin
      fails++; $display("FAIL model_sanity: got %h expected %h", model(4'b1000, 32'd123456, 32'd789, 32'd0), 32'd97406784);
    end
    test_mult("mult_zero_b", $urandom, 32'd0);
    for (int i = 0; i < 3; i++) test_mult("mult_rand", $urandom, $urandom);
    test_hi();
    test_back_to_back_mult();
    test_reset_mid_mult();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage consumer of the 4-bit ALUOp encoding produced by the instruction decoder.
- Takes two operands plus ALUOp and returns a registered Result and a Zero flag. Zero feeds the beq decision.
- Logic ops, add/sub and slt complete in one cycle.
- mult runs as an iterative shift-add state machine and stalls upstream with Stall while it runs.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MULT_STEP_BITS, 1, multiplier bits retired per cycle. Legal values: 1, 2, 4. Must divide WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/ALUOp valid this cycle.
- ALUOp  input  4  operation code from the decoder.
- A  input  WIDTH  operand 1 (rs).
- B  input  WIDTH  operand 2 (rt or sign-extended immediate).
- Stall  output  1  unit busy; upstream must hold its current instruction.
- out_valid  output  1  one-cycle pulse; Result/Zero valid.
- Result  output  WIDTH  operation result.
- Zero  output  1  high when Result == 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset values: state=IDLE, Stall=0, out_valid=0, Result=0, Zero=0, internal accumulator and counter=0.
- Reset mid-multiply aborts the operation; no out_valid is produced.
- Acceptance: an op is taken on a rising edge when in_valid=1 and state=IDLE. in_valid is ignored while state=MULT.
- Op encodings:
  - 0000 AND, 0001 OR, 1101 XOR, 1100 NOR.
  - 0010 ADD and 0110 SUB: modulo 2^WIDTH, no overflow trap.
  - 0111 SLT: signed compare, Result = {0..0, A<B}.
  - 1000 MULT: low WIDTH bits of the unsigned product.
  - 1111 (jump) and all other codes: Result=0, Zero=1.
- Single-cycle ops: accepted at edge N; Result, Zero and out_valid=1 are visible in cycle N+1. Latency 1, throughput 1 per cycle.
- out_valid stays low in cycles with no completion.
- Zero is registered together with Result and is held between pulses. Result is also held between pulses.
- FSM states: IDLE, MULT.
- IDLE -> MULT on acceptance of ALUOp=1000:
  - load multiplicand=A, multiplier=B, acc=0, cnt=WIDTH/MULT_STEP_BITS;
  - out_valid stays 0 at that edge.
- MULT, each cycle:
  - acc += multiplicand * multiplier[MULT_STEP_BITS-1:0], where the partial product is a sum of shifted copies;
  - multiplicand <<= MULT_STEP_BITS, multiplier >>= MULT_STEP_BITS, cnt -= 1;
  - on the edge where cnt reaches 0: Result=acc (including the final step), Zero updated, out_valid=1, state -> IDLE.
- Multiply latency is K+1, with K=WIDTH/MULT_STEP_BITS. Default: accepted at edge N, out_valid in cycle N+33.
- Stall = (state==MULT), purely state-decoded.
  - The issue cycle itself is not stalled, so upstream advances the instruction behind the mult once.
  - That instruction is held through the stall and accepted in the first IDLE cycle.
- Back-to-back multiplies: the second is accepted in the same cycle the first's out_valid is high.
- A multiplier operand of 0 still takes the full K cycles. There is no early exit, so latency is data-independent.

Optional Feature:
- Macro ALU_MULT_HI_EN.
- Defined:
  - the accumulator is 2*WIDTH bits wide;
  - on mult completion the upper WIDTH bits are stored in register HI (reset 0, not cleared by other ops);
  - ALUOp 1001 (mfhi) is a single-cycle op returning HI.
  - A reset mid-multiply leaves HI=0.
- Undefined: the accumulator is WIDTH bits, there is no HI register, and 1001 behaves as an unknown code (Result=0, Zero=1).

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_MULT=4'b1000, ALU_MFHI=4'b1001, ALU_NOR=4'b1100, ALU_XOR=4'b1101, ALU_JMP=4'b1111;
  - FSM state encoding.
  - The decoder must reuse the same constants.
- One sub-module: alu_mult_seq, the shift-add datapath with start/done, owning the accumulator, counter and HI.
- The top level keeps the combinational single-cycle ALU, output registers and Stall.

Test Plan:
- reset, then in_valid with ALUOp=0010, A=7, B=5 -> next cycle out_valid=1, Result=12, Zero=0. Repeat with ALUOp=0110, A=B=9 -> Result=0, Zero=1.
- ALUOp=0111, A=32'hFFFFFFFF, B=1 -> Result=1. A=1, B=32'hFFFFFFFF -> Result=0.
- ALUOp=1000, A=123456, B=789 with defaults:
  - Stall=1 for exactly 32 cycles;
  - out_valid only in cycle N+33, Result=97406784;
  - the ADD held behind it completes in cycle N+34.
- ALUOp=1000, A=B=32'hFFFFFFFF -> Result=1. With ALU_MULT_HI_EN, a following 1001 -> Result=32'hFFFFFFFE.
- reset asserted 10 cycles into a multiply -> next cycle Stall=0, out_valid=0, Result=0; a new ADD completes normally.
- ALUOp=1111 and 1010 -> Result=0, Zero=1, out_valid=1. Repeat mult with MULT_STEP_BITS=4 -> out_valid in cycle N+9.
